alu_issue: RTL and testbench

- Sequencer on the driving side of the ALU interface.
- Accepts one instruction word per handshake and reads both source registers from the register file.
- Drives alu_control/alu_oper1/alu_oper2, waits the fixed ALU latency, then samples alu_result.
- Retires by writing back to the register file or resolving a BEQ branch.

---
 rtl/alu_issue.sv | 131 +++++++++++++
 tb/tb_alu_issue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue sequencer for a fixed-latency ALU: accept, read RF, execute, retire.
// Optional ALU_ISSUE_PERF_EN adds perf_retired / perf_illegal counters.
module alu_issue #(
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] alu_oper1,
  output logic [DATA_W-1:0] alu_oper2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_en,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              branch_taken,
  output logic [15:0]       branch_offset,
  output logic              illegal_op
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_illegal
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, RETIRE} state_t;

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic [3:0]  cnt;
  logic [5:0]  opcode;
  logic [4:0]  rd;
  logic        is_rtype, is_beq, is_wb, last, accept;
  logic [3:0]  ctl_sel;

  assign opcode   = ir[31:26];
  assign rd       = ir[15:11];
  assign is_rtype = (opcode <= 6'd4);
  assign is_beq   = (opcode == 6'd30);
  assign is_wb    = is_rtype && (rd != 5'd0);
  assign last     = (state == EXEC) && (cnt == 4'd1);
  assign accept   = instr_valid && instr_ready;

  // Illegal ops still issue (as ADD) so every instruction has the same latency.
  always_comb begin
    ctl_sel = 4'd0;
    if (is_rtype)    ctl_sel = opcode[3:0];
    else if (is_beq) ctl_sel = 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    if (cnt == 4'd1) state_nxt = RETIRE;
      RETIRE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = rst_n && (state == IDLE);
    rf_raddr1   = ir[25:21];
    rf_raddr2   = ir[20:16];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir          <= '0;
      cnt         <= '0;
      alu_control <= '0;
      alu_oper1   <= '0;
      alu_oper2   <= '0;
    end else begin
      if (accept) ir <= instr;
      if (state == READ) begin
        alu_control <= ctl_sel;
        alu_oper1   <= rf_rdata1;
        alu_oper2   <= rf_rdata2;
        cnt         <= 4'(ALU_LAT);
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Retire strobes are set only on the EXEC->RETIRE edge, so they last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en         <= 1'b0;
      wb_addr       <= '0;
      wb_data       <= '0;
      branch_taken  <= 1'b0;
      branch_offset <= '0;
      illegal_op    <= 1'b0;
    end else begin
      wb_en         <= last && is_wb;
      wb_addr       <= (last && is_wb) ? rd : 5'd0;
      wb_data       <= (last && is_wb) ? alu_result : '0;
      branch_taken  <= last && is_beq && (alu_result == '0);
      branch_offset <= (last && is_beq && (alu_result == '0)) ? ir[15:0] : 16'd0;
      illegal_op    <= last && !is_rtype && !is_beq;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired <= '0;
      perf_illegal <= '0;
    end else begin
      if (state == RETIRE) perf_retired <= perf_retired + 32'd1;
      if (illegal_op)      perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: latency-checking ALU model, RF model, retire scoreboard.
module tb_alu_issue;
  localparam int DATA_W  = 32;
  localparam int ALU_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [31:0]       instr = '0;
  logic [4:0]        rf_raddr1, rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
  logic [3:0]        alu_control;
  logic [DATA_W-1:0] alu_oper1, alu_oper2, alu_result;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              branch_taken;
  logic [15:0]       branch_offset;
  logic              illegal_op;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]       perf_retired, perf_illegal;
`endif

  alu_issue #(.DATA_W(DATA_W), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .alu_control(alu_control),
    .alu_oper1(alu_oper1), .alu_oper2(alu_oper2), .alu_result(alu_result),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .illegal_op(illegal_op)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_retired(perf_retired), .perf_illegal(perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register file model: combinational reads, contents set by the stimulus only.
  logic [31:0] rf [32];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  // ALU model: result only valid once inputs have been stable ALU_LAT cycles.
  int          stable = 0;
  logic [3:0]  p_ctl = '0;
  logic [31:0] p_a = '0, p_b = '0;
  always @(negedge clk) begin
    stable <= ({alu_control, alu_oper1, alu_oper2} !== {p_ctl, p_a, p_b}) ? 1 : stable + 1;
    p_ctl  <= alu_control;
    p_a    <= alu_oper1;
    p_b    <= alu_oper2;
  end
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    if (stable >= ALU_LAT)
      case (alu_control)
        4'd0: alu_result = alu_oper1 + alu_oper2;
        4'd1: alu_result = alu_oper1 - alu_oper2;
        4'd2: alu_result = alu_oper1 * alu_oper2;
        4'd3: alu_result = alu_oper1 & alu_oper2;
        4'd4: alu_result = alu_oper1 | alu_oper2;
        default: alu_result = 32'hBAD0_BAD0;
      endcase
  end

  typedef struct {
    logic        wb;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        br;
    logic [15:0] off;
    logic        ill;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && (wb_en || branch_taken || illegal_op)) begin
      chk("retire_expected", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("sb_wb_en", wb_en, mon_e.wb);
        chk("sb_wb_addr", wb_addr, mon_e.addr);
        chk("sb_wb_data", wb_data, mon_e.data);
        chk("sb_branch", branch_taken, mon_e.br);
        chk("sb_offset", branch_offset, mon_e.off);
        chk("sb_illegal", illegal_op, mon_e.ill);
      end
    end
  end

  function automatic logic [31:0] ref_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'd0: return a + b;
      6'd1: return a - b;
      6'd2: return a * b;
      6'd3: return a & b;
      6'd4: return a | b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int low);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], low[15:0]};
    return w;
  endfunction

  task automatic push(input logic [31:0] w);
    exp_t e;
    logic [5:0] op;
    op = w[31:26];
    e = '{wb: 1'b0, addr: 5'd0, data: 32'd0, br: 1'b0, off: 16'd0, ill: 1'b0};
    if (op <= 6'd4 && w[15:11] != 5'd0) begin
      e.wb = 1'b1; e.addr = w[15:11]; e.data = ref_op(op, rf[w[25:21]], rf[w[20:16]]);
    end else if (op == 6'd30 && rf[w[25:21]] == rf[w[20:16]]) begin
      e.br = 1'b1; e.off = w[15:0];
    end else if (!(op <= 6'd4 || op == 6'd30)) begin
      e.ill = 1'b1;
    end
    if (e.wb || e.br || e.ill) sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in cycle 0 with the DUT idle; ends in cycle 3+ALU_LAT.
  task automatic run(input string tag, input logic [31:0] w);
    logic [5:0] op;
    logic [3:0] ctl;
    logic       x_wb, x_br, x_ill;
    op    = w[31:26];
    ctl   = (op <= 6'd4) ? op[3:0] : ((op == 6'd30) ? 4'd1 : 4'd0);
    x_wb  = (op <= 6'd4) && (w[15:11] != 5'd0);
    x_br  = (op == 6'd30) && (rf[w[25:21]] == rf[w[20:16]]);
    x_ill = !((op <= 6'd4) || (op == 6'd30));
    push(w);
    instr = w; instr_valid = 1'b1;
    chk({tag, "_ready_c0"}, instr_ready, 1);
    tick(); instr_valid = 1'b0; instr = $urandom;
    chk({tag, "_raddr1"}, rf_raddr1, w[25:21]);
    chk({tag, "_raddr2"}, rf_raddr2, w[20:16]);
    chk({tag, "_ready_c1"}, instr_ready, 0);
    tick();
    chk({tag, "_ctl"}, alu_control, ctl);
    chk({tag, "_oper1"}, alu_oper1, rf[w[25:21]]);
    chk({tag, "_oper2"}, alu_oper2, rf[w[20:16]]);
    repeat (ALU_LAT) tick();
    chk({tag, "_wb_en"}, wb_en, x_wb);
    chk({tag, "_branch"}, branch_taken, x_br);
    chk({tag, "_illegal"}, illegal_op, x_ill);
    chk({tag, "_ready_retire"}, instr_ready, 0);
    tick();
    chk({tag, "_ready_back"}, instr_ready, 1);
    chk({tag, "_wb_en_drop"}, wb_en, 0);
  endtask

  logic [31:0] w1, w2;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] pr0, pi0;
`endif

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3 + 1);
    rf[0] = 0; rf[1] = 5; rf[2] = 7; rf[4] = 9; rf[5] = 9; rf[3] = 32'h1234; rf[9] = 32'h00F0_0F00;

    #12;
    chk("rst_ready", instr_ready, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_ctl", alu_control, 0);
    chk("rst_oper1", alu_oper1, 0);
    chk("rst_raddr1", rf_raddr1, 0);
    chk("rst_branch", branch_taken, 0);
    chk("rst_illegal", illegal_op, 0);
    @(posedge clk); #1; rst_n = 1'b1; #1;
    chk("rst_release_ready", instr_ready, 1);
`ifdef ALU_ISSUE_PERF_EN
    chk("rst_perf_retired", perf_retired, 0);
    chk("rst_perf_illegal", perf_illegal, 0);
`endif
    tick();

    run("add", mk(0, 1, 2, 3 << 11));
    run("beq_taken", mk(30, 4, 5, 16'h0010));
    rf[5] = 8;
    run("beq_not", mk(30, 4, 5, 16'h0010));
`ifdef ALU_ISSUE_PERF_EN
    pr0 = perf_retired; pi0 = perf_illegal;
`endif
    run("illegal", mk(17, 1, 2, 3 << 11));
`ifdef ALU_ISSUE_PERF_EN
    chk("perf_illegal_inc", perf_illegal, pi0 + 1);
    chk("perf_retired_inc", perf_retired, pr0 + 1);
`endif
    run("mul_r0", mk(2, 1, 2, 0));

    for (int op = 0; op < 5; op++) begin
      rf[11] = $urandom; rf[12] = $urandom;
      run($sformatf("op%0d", op), mk(op, 11, 12, (20 + op) << 11));
    end

    // Back-pressure: second word offered during EXEC must wait for IDLE.
    w1 = mk(0, 1, 2, 6 << 11);
    w2 = mk(4, 3, 9, 8 << 11);
    push(w1);
    instr = w1; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    tick();
    instr = w2; instr_valid = 1'b1;
    chk("bp_ready_c2", instr_ready, 0);
    tick();
    chk("bp_ready_c3", instr_ready, 0);
    chk("bp_not_latched", rf_raddr1, 1);
    tick();
    chk("bp_first_wb", wb_en, 1);
    chk("bp_ready_c4", instr_ready, 0);
    push(w2);
    tick();
    chk("bp_ready_c5", instr_ready, 1);
    tick(); instr_valid = 1'b0;
    chk("bp_second_raddr1", rf_raddr1, 3);
    chk("bp_second_raddr2", rf_raddr2, 9);
    repeat (ALU_LAT + 1) tick();
    chk("bp_second_wb", wb_en, 1);
    tick();
    chk("bp_ready_end", instr_ready, 1);

    // Reset during EXEC: instruction abandoned, nothing pushed to the scoreboard.
    instr = mk(1, 3, 2, 7 << 11); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    tick();
    chk("rmid_oper1_live", alu_oper1, rf[3]);
    rst_n = 1'b0; #1;
    chk("rmid_oper1", alu_oper1, 0);
    chk("rmid_ctl", alu_control, 0);
    chk("rmid_ready", instr_ready, 0);
    chk("rmid_raddr1", rf_raddr1, 0);
    @(posedge clk); #1; rst_n = 1'b1; #1;
    chk("rmid_ready_release", instr_ready, 1);
    repeat (ALU_LAT + 2) tick();
    chk("rmid_no_wb", wb_en, 0);
    chk("rmid_ready_idle", instr_ready, 1);
`ifdef ALU_ISSUE_PERF_EN
    chk("rmid_perf_retired", perf_retired, 0);
`endif
    run("after_rst", mk(3, 1, 2, 10 << 11));

    chk("sb_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
